// File: rtl/i2c_write_master_if.sv
// Command / status / pad bundle between the APB register stage, the I2C write
// engine and the pad wrapper.
interface i2c_write_master_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] cmd_data;   // [6:0] slave address, [15:8] data byte
    logic                  cmd_valid;  // one-cycle request strobe
    logic                  cmd_ready;  // idle and able to accept a command
    logic                  scl;        // push-pull I2C clock
    logic                  sda_oe;     // 1 pulls SDA low, 0 releases it
    logic                  sda_i;      // SDA pad input
    logic                  busy;
    logic                  done;       // one-cycle pulse at end of STOP
    logic                  ack_err;    // sticky NACK flag for the last transaction

    // Engine side.
    modport master (
        input  cmd_data,
        input  cmd_valid,
        input  sda_i,
        output cmd_ready,
        output scl,
        output sda_oe,
        output busy,
        output done,
        output ack_err
    );

    // Register stage / pad side.
    modport slave (
        output cmd_data,
        output cmd_valid,
        output sda_i,
        input  cmd_ready,
        input  scl,
        input  sda_oe,
        input  busy,
        input  done,
        input  ack_err
    );
endinterface

// File: rtl/i2c_write_master.sv
// Single-byte I2C write engine: START, {addr, W}, ACK, data, ACK, STOP.
// Time is divided into slots of four quarters of CLK_DIV clocks each; line levels
// are decoded from the upcoming slot position and registered, so scl/sda_oe are
// glitch-free flop outputs.
module i2c_write_master #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CLK_DIV    = 250
) (
    input logic                clk,
    input logic                reset,
    i2c_write_master_if.master bus
);

    localparam int unsigned TimerW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [TimerW-1:0] TimerLast = TimerW'(CLK_DIV - 1);

    if (CLK_DIV < 2) begin : gen_bad_clk_div
        $error("CLK_DIV must be at least 2");
    end
    if (DATA_WIDTH < 16) begin : gen_bad_data_width
        $error("DATA_WIDTH must hold the address and data fields");
    end

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StAddr,
        StAddrAck,
        StData,
        StDataAck,
        StStop
    } state_e;

    state_e              state_q, state_d;
    logic [1:0]          quarter_q, quarter_d;
    logic [TimerW-1:0]   timer_q, timer_d;
    logic [2:0]          bit_q, bit_d;
    logic [6:0]          addr_q, addr_d;
    logic [7:0]          data_q, data_d;
    logic                ack_err_q, ack_err_d;
    logic                done_d;
    logic                scl_q, scl_d;
    logic                sda_oe_q, sda_oe_d;
    logic                busy_q;
    logic                done_q;
    logic                ready_q;
    logic [7:0]          addr_byte;
    logic                tx_bit;

    // Only the address and data fields of the command word are meaningful.
    logic unused_cmd_bits;
    assign unused_cmd_bits = ^bus.cmd_data;

    // Next slot position, command capture and ACK sampling.
    always_comb begin
        state_d   = state_q;
        quarter_d = quarter_q;
        timer_d   = timer_q;
        bit_d     = bit_q;
        addr_d    = addr_q;
        data_d    = data_q;
        ack_err_d = ack_err_q;
        done_d    = 1'b0;

        if (state_q == StIdle) begin
            if (bus.cmd_valid && ready_q) begin
                state_d   = StStart;
                quarter_d = 2'd0;
                timer_d   = '0;
                bit_d     = 3'd7;
                addr_d    = bus.cmd_data[6:0];
                data_d    = bus.cmd_data[15:8];
                ack_err_d = 1'b0;
            end
        end else if (timer_q != TimerLast) begin
            timer_d = timer_q + TimerW'(1);
        end else begin
            timer_d   = '0;
            quarter_d = quarter_q + 2'd1;

            // SDA is sampled on the last clock of Q1, while SCL is high.
            if ((quarter_q == 2'd1) && bus.sda_i &&
                ((state_q == StAddrAck) || (state_q == StDataAck))) begin
                ack_err_d = 1'b1;
            end

            if (quarter_q == 2'd3) begin
                case (state_q)
                    StStart: begin
                        state_d = StAddr;
                        bit_d   = 3'd7;
                    end
                    StAddr: begin
                        if (bit_q == 3'd0) begin
                            state_d = StAddrAck;
                            bit_d   = 3'd7;
                        end else begin
                            bit_d = bit_q - 3'd1;
                        end
                    end
                    // ack_err_q was cleared on accept, so here it reflects the
                    // address ACK sampled earlier in this slot.
                    StAddrAck: state_d = ack_err_q ? StStop : StData;
                    StData: begin
                        if (bit_q == 3'd0) begin
                            state_d = StDataAck;
                            bit_d   = 3'd7;
                        end else begin
                            bit_d = bit_q - 3'd1;
                        end
                    end
                    StDataAck: state_d = StStop;
                    StStop: begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end
                    default: state_d = StIdle;
                endcase
            end
        end
    end

    assign addr_byte = {addr_d, 1'b0};
    assign tx_bit    = (state_d == StAddr) ? addr_byte[bit_d] : data_d[bit_d];

    // Line levels for the upcoming slot position.
    always_comb begin
        scl_d    = 1'b1;
        sda_oe_d = 1'b0;
        case (state_d)
            StStart: sda_oe_d = quarter_d[1];
            StAddr, StData: begin
                scl_d    = ^quarter_d;
                sda_oe_d = ~tx_bit;
            end
            StAddrAck, StDataAck: scl_d = ^quarter_d;
            StStop: begin
                scl_d    = (quarter_d != 2'd0);
                sda_oe_d = ~quarter_d[1];
            end
            default: begin
                scl_d    = 1'b1;
                sda_oe_d = 1'b0;
            end
        endcase
    end

    // FSM state, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            quarter_q <= 2'd0;
            timer_q   <= '0;
            bit_q     <= 3'd0;
            addr_q    <= 7'd0;
            data_q    <= 8'd0;
            ack_err_q <= 1'b0;
            scl_q     <= 1'b1;
            sda_oe_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            quarter_q <= quarter_d;
            timer_q   <= timer_d;
            bit_q     <= bit_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            ack_err_q <= ack_err_d;
            scl_q     <= scl_d;
            sda_oe_q  <= sda_oe_d;
            busy_q    <= (state_d != StIdle);
            done_q    <= done_d;
            ready_q   <= (state_d == StIdle);
        end
    end

    assign bus.cmd_ready = ready_q;
    assign bus.scl       = scl_q;
    assign bus.sda_oe    = sda_oe_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.ack_err   = ack_err_q;

endmodule

// File: tb/tb_i2c_write_master.sv
// Bench for i2c_write_master: a bus monitor decodes START/bytes/ACK/STOP from the
// pad lines and plays an addressable slave; each transaction is predicted from
// the command word and the chosen ACK responses.
module tb_i2c_write_master;

    localparam int unsigned CLK_DIV  = 2;
    localparam int          SlotClks = 4 * CLK_DIV;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    i2c_write_master_if #(.DATA_WIDTH(32)) bus ();

    i2c_write_master #(
        .DATA_WIDTH(32),
        .CLK_DIV   (CLK_DIV)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int n_total = 0;
    int n_pass  = 0;

    // Slave model: ack_plan[0] = ACK the address byte, ack_plan[1] = ACK the data byte.
    logic [1:0] ack_plan   = 2'b11;
    logic       slave_pull = 1'b0;
    assign bus.sda_i = ~(bus.sda_oe | slave_pull);

    // Monitor state (written only by the monitor process).
    logic [7:0] mon_bytes[$];
    logic       mon_acks[$];
    int         mon_starts   = 0;
    int         mon_stops    = 0;
    int         mon_bitpos   = 0;
    int         mon_byte_idx = 0;
    logic [7:0] mon_shreg    = 8'h00;
    logic       mon_line;
    logic       scl_prev     = 1'b1;
    logic       sda_prev     = 1'b1;

    // Expected transaction and monitor snapshot at launch.
    logic [7:0] exp_bytes[$];
    logic       exp_acks[$];
    logic       exp_err;
    int         exp_len;
    int         base_bytes, base_acks, base_starts, base_stops;

    // Bus decoder and slave, sampled away from the DUT's active edge.
    always @(negedge clk) begin
        mon_line = ~(bus.sda_oe | slave_pull);
        if (reset) begin
            slave_pull = 1'b0;
            mon_bitpos = 0;
        end else if (scl_prev && bus.scl && sda_prev && !mon_line) begin
            mon_starts++;
            mon_bitpos   = 0;
            mon_byte_idx = 0;
        end else if (scl_prev && bus.scl && !sda_prev && mon_line) begin
            mon_stops++;
            mon_bitpos = 0;
        end else if (!scl_prev && bus.scl) begin
            if (mon_bitpos < 8) begin
                mon_shreg = {mon_shreg[6:0], mon_line};
                mon_bitpos++;
                if (mon_bitpos == 8) mon_bytes.push_back(mon_shreg);
            end else begin
                mon_acks.push_back(mon_line);
                mon_bitpos = 9;
            end
        end else if (scl_prev && !bus.scl) begin
            if (mon_bitpos == 8) begin
                slave_pull = (mon_byte_idx < 2) ? ack_plan[mon_byte_idx] : 1'b0;
            end else if (mon_bitpos == 9) begin
                slave_pull = 1'b0;
                mon_bitpos = 0;
                mon_byte_idx++;
            end
        end
        scl_prev = bus.scl;
        sda_prev = ~(bus.sda_oe | slave_pull);
    end

    // Predict one transaction from the command word and slave responses.
    task automatic model_txn(input logic [31:0] cmd, input bit a_ack, input bit d_ack);
        exp_bytes.delete();
        exp_acks.delete();
        exp_bytes.push_back({cmd[6:0], 1'b0});
        exp_acks.push_back(!a_ack);
        if (a_ack) begin
            exp_bytes.push_back(cmd[15:8]);
            exp_acks.push_back(!d_ack);
        end
        exp_err     = !(a_ack && d_ack);
        exp_len     = (a_ack ? 20 : 11) * SlotClks;
        ack_plan    = {d_ack, a_ack};
        base_bytes  = mon_bytes.size();
        base_acks   = mon_acks.size();
        base_starts = mon_starts;
        base_stops  = mon_stops;
    endtask

    // Issue a command at a negedge; returns at the first busy cycle.
    task automatic launch(input logic [31:0] cmd, input bit a_ack, input bit d_ack,
                          input bit wait_ready);
        int guard = 0;
        if (wait_ready) begin
            while (bus.cmd_ready !== 1'b1 && guard < 1000) begin
                @(negedge clk);
                guard++;
            end
        end
        n_total++;
        if (bus.cmd_ready !== 1'b1)
            $display("FAIL launch_ready: cmd_ready=%b, required 1", bus.cmd_ready);
        else n_pass++;
        model_txn(cmd, a_ack, d_ack);
        bus.cmd_data  = cmd;
        bus.cmd_valid = 1'b1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        n_total++;
        if ({bus.busy, bus.cmd_ready, bus.ack_err} !== 3'b100)
            $display("FAIL accept_status: busy/ready/ack_err=%b, required 100",
                     {bus.busy, bus.cmd_ready, bus.ack_err});
        else n_pass++;
    endtask

    // Run to done (optionally poking cmd_valid at cycle poke_at) and check the
    // decoded bus traffic; returns in the done cycle.
    task automatic complete(input int poke_at, input logic [31:0] poke_cmd);
        int cyc = 0;
        while (bus.done !== 1'b1 && cyc < exp_len + 40) begin
            @(negedge clk);
            cyc++;
            if (cyc == poke_at) begin
                bus.cmd_data  = poke_cmd;
                bus.cmd_valid = 1'b1;
            end else begin
                bus.cmd_valid = 1'b0;
            end
        end
        bus.cmd_valid = 1'b0;
        n_total++;
        if (cyc != exp_len) $display("FAIL duration: done after %0d clocks, required %0d",
                                     cyc, exp_len);
        else n_pass++;
        n_total++;
        if ({bus.busy, bus.cmd_ready, bus.ack_err} !== {2'b01, exp_err})
            $display("FAIL done_status: busy/ready/ack_err=%b, required %b",
                     {bus.busy, bus.cmd_ready, bus.ack_err}, {2'b01, exp_err});
        else n_pass++;
        n_total++;
        if ((mon_starts - base_starts) != 1 || (mon_stops - base_stops) != 1)
            $display("FAIL start_stop: starts=%0d stops=%0d, required 1 and 1",
                     mon_starts - base_starts, mon_stops - base_stops);
        else n_pass++;
        n_total++;
        if ((mon_bytes.size() - base_bytes) != exp_bytes.size())
            $display("FAIL byte_count: %0d bytes on bus, required %0d",
                     mon_bytes.size() - base_bytes, exp_bytes.size());
        else n_pass++;
        for (int i = 0; i < exp_bytes.size(); i++) begin
            if (base_bytes + i < mon_bytes.size()) begin
                n_total++;
                if (mon_bytes[base_bytes + i] !== exp_bytes[i])
                    $display("FAIL bus_byte%0d: got %02h, required %02h",
                             i, mon_bytes[base_bytes + i], exp_bytes[i]);
                else n_pass++;
            end
        end
        n_total++;
        if ((mon_acks.size() - base_acks) != exp_acks.size())
            $display("FAIL ack_count: %0d ACK slots, required %0d",
                     mon_acks.size() - base_acks, exp_acks.size());
        else begin
            n_pass++;
            for (int i = 0; i < exp_acks.size(); i++) begin
                n_total++;
                if (mon_acks[base_acks + i] !== exp_acks[i])
                    $display("FAIL ack_level%0d: SDA=%b, required %b",
                             i, mon_acks[base_acks + i], exp_acks[i]);
                else n_pass++;
            end
        end
    endtask

    // One cycle after done: pulse ended, still idle, ack_err held.
    task automatic after_done();
        @(negedge clk);
        n_total++;
        if ({bus.done, bus.busy, bus.cmd_ready, bus.ack_err} !== {3'b001, exp_err})
            $display("FAIL post_done: done/busy/ready/ack_err=%b, required %b",
                     {bus.done, bus.busy, bus.cmd_ready, bus.ack_err}, {3'b001, exp_err});
        else n_pass++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_total++;
            if ({bus.scl, bus.sda_oe, bus.busy, bus.done, bus.ack_err, bus.cmd_ready} !== 6'b100001)
                $display("FAIL idle_state cycle %0d: scl/oe/busy/done/err/ready=%b, required 100001",
                         i, {bus.scl, bus.sda_oe, bus.busy, bus.done, bus.ack_err, bus.cmd_ready});
            else n_pass++;
        end
    endtask

    task automatic test_ack_path();
        launch(32'h0000_A550, 1'b1, 1'b1, 1'b1);
        complete(-1, 32'h0);
        after_done();
    endtask

    task automatic test_addr_nack();
        launch(32'h0000_3C2A, 1'b0, 1'b1, 1'b1);
        complete(-1, 32'h0);
        after_done();
    endtask

    task automatic test_data_nack();
        launch($urandom, 1'b1, 1'b0, 1'b1);
        complete(-1, 32'h0);
        after_done();
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            launch($urandom, ($urandom_range(0, 3) != 0), ($urandom_range(0, 1) != 0), 1'b1);
            complete(-1, 32'h0);
            after_done();
        end
    endtask

    // Busy-time request is dropped; a request in the done cycle is taken.
    task automatic test_back_to_back();
        logic [31:0] first_cmd;
        logic [31:0] stray_cmd;
        first_cmd = $urandom;
        stray_cmd = ~first_cmd;
        launch(first_cmd, 1'b0, 1'b1, 1'b1);
        complete(10, stray_cmd);
        launch($urandom, 1'b1, 1'b1, 1'b0);
        complete(-1, 32'h0);
        after_done();
    endtask

    task automatic test_reset_mid();
        launch($urandom, 1'b1, 1'b1, 1'b1);
        repeat (60) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_total++;
        if ({bus.scl, bus.sda_oe, bus.busy, bus.done, bus.ack_err, bus.cmd_ready} !== 6'b100001)
            $display("FAIL abort_state: scl/oe/busy/done/err/ready=%b, required 100001",
                     {bus.scl, bus.sda_oe, bus.busy, bus.done, bus.ack_err, bus.cmd_ready});
        else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_total++;
            if ({bus.done, bus.busy} !== 2'b00)
                $display("FAIL abort_quiet cycle %0d: done/busy=%b, required 00",
                         i, {bus.done, bus.busy});
            else n_pass++;
        end
        launch($urandom, 1'b1, 1'b1, 1'b1);
        complete(-1, 32'h0);
        after_done();
    endtask

    initial begin
        bus.cmd_data  = 32'h0;
        bus.cmd_valid = 1'b0;
        test_reset();
        test_ack_path();
        test_addr_nack();
        test_data_nack();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/i2c_write_master.md
Name: i2c_write_master

Overview:
- Downstream consumer of the APB peripheral-register stage.
- Takes the command word written by the APB side and performs one I2C single-byte write: START, 7-bit address + W, ACK, data byte, ACK, STOP.
- Drives SCL push-pull and SDA open-drain to the pad wrapper.
- Reports busy, done and ACK-error status back for APB readback.

Parameters:
- DATA_WIDTH, 32, width of the command word (matches the APB data width).
- CLK_DIV, 250, system clocks per SCL quarter-period; SCL period = 4*CLK_DIV clocks; legal range ≥ 2.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- cmd_data  in  DATA_WIDTH  command word; [6:0] slave address, [15:8] data byte, other bits ignored.
- cmd_valid  in  1  one-cycle request strobe.
- cmd_ready  out  1  high when idle and able to accept a command.
- scl  out  1  I2C clock, push-pull.
- sda_oe  out  1  1 = pull SDA low; 0 = release SDA (pull-up gives 1).
- sda_i  in  1  SDA pad input.
- busy  out  1  transaction in progress.
- done  out  1  one-cycle pulse at end of STOP.
- ack_err  out  1  sticky NACK flag for the last transaction.

Behaviour:
- Reset: scl=1, sda_oe=0, busy=0, done=0, ack_err=0, cmd_ready=1, state IDLE, all counters 0.
- Reset asserted mid-transaction aborts on the next edge: lines return to released/idle immediately, no STOP sequence, no done pulse.
- Accept condition: cmd_valid & cmd_ready.
  - Latch addr = cmd_data[6:0] and data = cmd_data[15:8].
  - Clear ack_err.
  - busy=1 and cmd_ready=0 from the next cycle.
- cmd_valid while busy is ignored; there is no queueing.
- Quarter timer counts 0..CLK_DIV-1; a quarter ends when the timer reaches CLK_DIV-1. Each slot is 4 quarters Q0..Q3.
- FSM states: IDLE, START, ADDR, ADDR_ACK, DATA, DATA_ACK, STOP.
- START slot:
  - Q0,Q1: scl=1, sda released.
  - Q2,Q3: scl=1, sda_oe=1.
- Bit slot (ADDR, DATA, and both ACK states):
  - SDA changes only at the start of Q0; SCL = 0,1,1,0 over Q0..Q3.
  - sda_i is sampled on the last clock of Q1.
- ADDR: 8 bit slots sending {addr, 1'b0}, MSB first. sda_oe = ~bit.
- ADDR_ACK: one slot with SDA released.
  - Sampled 0: continue to DATA.
  - Sampled 1: set ack_err and go directly to STOP.
- DATA: 8 slots sending the data byte, MSB first.
- DATA_ACK: one slot with SDA released; sampled 1 sets ack_err. Then go to STOP.
- STOP slot:
  - Q0: scl=0, sda_oe=1.
  - Q1: scl=1, sda_oe=1.
  - Q2,Q3: scl=1, sda released.
- End of STOP: done=1 for one cycle, busy=0 and cmd_ready=1 in that same cycle, state IDLE. A new command is accepted from that cycle.
- Total duration from first busy cycle to done:
  - ACK path: 80*CLK_DIV clocks (1+9+9+1 slots).
  - Address-NACK path: 44*CLK_DIV clocks.
- ack_err holds until the next accepted command or reset.
- Bit counter is 3 bits (7 down to 0); wrap to 7 only on a state change.
- No clock stretching and no arbitration: sda_i is read only in ACK slots.

Test Plan (CLK_DIV=2):
- Reset then idle 20 cycles → scl=1, sda_oe=0, busy=0, done=0, ack_err=0, cmd_ready=1 throughout.
- cmd_data=32'h0000_A550, bench ACKs every slot → bus decodes START, 0xA0, ACK, 0xA5, ACK, STOP; done pulses exactly 160 clocks after busy rises; ack_err=0.
- cmd_data=32'h0000_3C2A, bench holds sda_i=1 in the address ACK slot → address byte 0x54, ack_err=1, no data bits, STOP follows immediately; done 88 clocks after busy rises.
- Address ACKed, data NACKed (sda_i=1 in DATA_ACK) → full 160-clock transaction, ack_err=1 after done.
- Second cmd_valid pulsed 10 cycles into a transaction → ignored; only one START on the bus. A cmd_valid in the done cycle is accepted and ack_err clears.
- Reset asserted at clock 60 of a transaction → next edge: scl=1, sda_oe=0, busy=0, no done pulse; a following command runs normally.
